// File: rtl/adder_sweep_ctrl.sv
// adder_sweep_ctrl
// ----------------
// Exhaustive-sweep controller for checking a DUT adder against a reference
// adder. Every {A, B, cin} combination is presented once per clock. Each
// clock the controller compares the two sum/carry results, keeps a
// saturating mismatch count, and captures the first failing vector.
// A start/done handshake frames each sweep.
//
// Parameters
//   W   operand width of each adder
//   CW  width of the saturating mismatch counter
//
// Ports
//   clk, rst_n           rising-edge clock; asynchronous active-low reset
//   start                begin a sweep (honoured in IDLE or DONE only)
//   abort                stop a running sweep and return to IDLE
//   a_o, b_o, cin_o      current vector, driven to both adders
//   sum_ref, cout_ref    reference adder result
//   sum_dut, cout_dut    DUT adder result
//   busy                 high while sweeping
//   done                 high (level) once a full sweep has completed
//   pass                 done with zero mismatches
//   err_cnt              number of mismatching vectors (saturating)
//   first_a/b/cin        operands of the first mismatching vector
//   first_vld            first_* hold a captured vector
module adder_sweep_ctrl #(
   parameter int W  = 8,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   output logic [W-1:0]  a_o,
   output logic [W-1:0]  b_o,
   output logic          cin_o,
   input  logic [W-1:0]  sum_ref,
   input  logic          cout_ref,
   input  logic [W-1:0]  sum_dut,
   input  logic          cout_dut,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [CW-1:0] err_cnt,
   output logic [W-1:0]  first_a,
   output logic [W-1:0]  first_b,
   output logic          first_cin,
   output logic          first_vld
);

   localparam int VW = 2*W + 1;
   localparam logic [VW-1:0] VEC_ONE = VW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [VW-1:0] vec;
   logic          clr;
   logic          cmp_en;
   logic          adv;
   logic          mismatch;
   logic          last_vec;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      sat_inc = (&v) ? v : v + CNT_ONE;
   endfunction

   // Vector layout {A, B, cin}: cin toggles fastest, A slowest.
   assign a_o      = vec[VW-1:W+1];
   assign b_o      = vec[W:1];
   assign cin_o    = vec[0];

   assign mismatch = (sum_ref != sum_dut) || (cout_ref != cout_dut);
   assign last_vec = &vec;

   assign busy = (state == RUN);
   assign done = (state == DONE);
   assign pass = done && (err_cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // abort takes priority over the final-vector transition, and an aborted
   // cycle is not compared, so all results freeze at their pre-abort values.
   always_comb begin
      state_nxt = state;
      clr       = 1'b0;
      cmp_en    = 1'b0;
      adv       = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt = RUN;
               clr       = 1'b1;
            end
         end
         RUN: begin
            if (abort) begin
               state_nxt = IDLE;
            end else begin
               cmp_en = 1'b1;
               if (last_vec) begin
                  state_nxt = DONE;
               end else begin
                  adv = 1'b1;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec       <= '0;
         err_cnt   <= '0;
         first_a   <= '0;
         first_b   <= '0;
         first_cin <= 1'b0;
         first_vld <= 1'b0;
      end else if (clr) begin
         vec       <= '0;
         err_cnt   <= '0;
         first_a   <= '0;
         first_b   <= '0;
         first_cin <= 1'b0;
         first_vld <= 1'b0;
      end else begin
         if (adv) begin
            vec <= vec + VEC_ONE;
         end
         if (cmp_en && mismatch) begin
            err_cnt <= sat_inc(err_cnt);
            // Only the earliest failing vector is kept.
            if (!first_vld) begin
               first_vld <= 1'b1;
               first_a   <= vec[VW-1:W+1];
               first_b   <= vec[W:1];
               first_cin <= vec[0];
            end
         end
      end
   end

endmodule

// File: tb/tb_adder_sweep_ctrl.sv
// Bench for adder_sweep_ctrl with W=2. Two instances share stimulus:
// dut_m (CW=16) and dut_s (CW=3, to exercise counter saturation).
// The DUT-side adder can have its carry-out stuck at 0 via 'fault'.
module tb_adder_sweep_ctrl;

   logic clk;
   logic rst_n;
   logic start;
   logic abort;
   logic fault;

   logic [1:0] a_m, b_m, sr_m, sd_m, fa_m, fb_m;
   logic       c_m, cr_m, cd_m, busy_m, done_m, pass_m, fc_m, fv_m;
   logic [15:0] err_m;

   logic [1:0] a_s, b_s, sr_s, sd_s, fa_s, fb_s;
   logic       c_s, cr_s, cd_s, busy_s, done_s, pass_s, fc_s, fv_s;
   logic [2:0] err_s;

   int errors;
   int checks;

   // Reference adders and (optionally faulty) DUT adders.
   assign {cr_m, sr_m} = {1'b0, a_m} + {1'b0, b_m} + {2'b00, c_m};
   assign sd_m = sr_m;
   assign cd_m = fault ? 1'b0 : cr_m;
   assign {cr_s, sr_s} = {1'b0, a_s} + {1'b0, b_s} + {2'b00, c_s};
   assign sd_s = sr_s;
   assign cd_s = fault ? 1'b0 : cr_s;

   adder_sweep_ctrl #(.W(2), .CW(16)) dut_m (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .a_o(a_m), .b_o(b_m), .cin_o(c_m),
      .sum_ref(sr_m), .cout_ref(cr_m), .sum_dut(sd_m), .cout_dut(cd_m),
      .busy(busy_m), .done(done_m), .pass(pass_m), .err_cnt(err_m),
      .first_a(fa_m), .first_b(fb_m), .first_cin(fc_m), .first_vld(fv_m)
   );

   adder_sweep_ctrl #(.W(2), .CW(3)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .a_o(a_s), .b_o(b_s), .cin_o(c_s),
      .sum_ref(sr_s), .cout_ref(cr_s), .sum_dut(sd_s), .cout_dut(cd_s),
      .busy(busy_s), .done(done_s), .pass(pass_s), .err_cnt(err_s),
      .first_a(fa_s), .first_b(fb_s), .first_cin(fc_s), .first_vld(fv_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse start for one clock; returns at the negedge after the start edge.
   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Count negedge samples with busy high; bounded so a stuck FSM still ends.
   task automatic count_busy(output int cycles);
      cycles = 0;
      while (busy_m && cycles < 100) begin
         cycles++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++; if ({a_m, b_m, c_m} !== 5'd0) begin errors++;
         $display("FAIL reset_vec: got %0d expected 0", {a_m, b_m, c_m}); end
      checks++; if ({busy_m, done_m, pass_m} !== 3'b000) begin errors++;
         $display("FAIL reset_flags: got %b expected 000", {busy_m, done_m, pass_m}); end
      checks++; if (err_m !== 16'd0) begin errors++;
         $display("FAIL reset_err: got %0d expected 0", err_m); end
      checks++; if ({fa_m, fb_m, fc_m, fv_m} !== 6'd0) begin errors++;
         $display("FAIL reset_first: got %b expected 000000", {fa_m, fb_m, fc_m, fv_m}); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if ({busy_m, done_m} !== 2'b00) begin errors++;
         $display("FAIL reset_idle: got %b expected 00", {busy_m, done_m}); end
   endtask

   task automatic test_sweep_pass();
      int cyc;
      fault = 1'b0;
      pulse_start();
      checks++; if ({busy_m, a_m, b_m, c_m} !== 6'b100000) begin errors++;
         $display("FAIL pass_start: got %b expected 100000", {busy_m, a_m, b_m, c_m}); end
      count_busy(cyc);
      checks++; if (cyc !== 32) begin errors++;
         $display("FAIL pass_len: got %0d expected 32", cyc); end
      checks++; if ({done_m, pass_m, fv_m} !== 3'b110) begin errors++;
         $display("FAIL pass_flags: got %b expected 110", {done_m, pass_m, fv_m}); end
      checks++; if (err_m !== 16'd0) begin errors++;
         $display("FAIL pass_err: got %0d expected 0", err_m); end
      checks++; if ({a_m, b_m, c_m} !== 5'd31) begin errors++;
         $display("FAIL pass_vec: got %0d expected 31", {a_m, b_m, c_m}); end
      checks++; if ({done_s, pass_s} !== 2'b11) begin errors++;
         $display("FAIL pass_sat_flags: got %b expected 11", {done_s, pass_s}); end
   endtask

   // cout stuck at 0: vectors with a+b+cin >= 4 fail, 16 in all; the first
   // in sweep order is a=0, b=3, cin=1.
   task automatic test_stuck_fault();
      int cyc;
      fault = 1'b1;
      pulse_start();
      checks++; if ({done_m, busy_m} !== 2'b01) begin errors++;
         $display("FAIL stuck_restart: got %b expected 01", {done_m, busy_m}); end
      count_busy(cyc);
      checks++; if (cyc !== 32) begin errors++;
         $display("FAIL stuck_len: got %0d expected 32", cyc); end
      checks++; if (err_m !== 16'd16) begin errors++;
         $display("FAIL stuck_err: got %0d expected 16", err_m); end
      checks++; if ({done_m, pass_m} !== 2'b10) begin errors++;
         $display("FAIL stuck_flags: got %b expected 10", {done_m, pass_m}); end
      checks++; if ({fv_m, fa_m, fb_m, fc_m} !== 6'b1_00_11_1) begin errors++;
         $display("FAIL stuck_first: got %b expected 100111", {fv_m, fa_m, fb_m, fc_m}); end
      checks++; if (err_s !== 3'd7) begin errors++;
         $display("FAIL sat_err: got %0d expected 7", err_s); end
      checks++; if ({done_s, pass_s, fv_s, fa_s, fb_s, fc_s} !== 8'b10_1_00_11_1) begin errors++;
         $display("FAIL sat_first: got %b expected 10100111", {done_s, pass_s, fv_s, fa_s, fb_s, fc_s}); end
   endtask

   // Abort during cycle 10: V=10 (a=1, b=1, cin=0) holds, err_cnt=1 from V=7.
   task automatic test_abort();
      int cyc;
      fault = 1'b1;
      pulse_start();
      repeat (10) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++; if ({busy_m, done_m} !== 2'b00) begin errors++;
         $display("FAIL abort_flags: got %b expected 00", {busy_m, done_m}); end
      checks++; if ({a_m, b_m, c_m} !== 5'd10) begin errors++;
         $display("FAIL abort_vec: got %0d expected 10", {a_m, b_m, c_m}); end
      checks++; if ({err_m, fv_m} !== {16'd1, 1'b1}) begin errors++;
         $display("FAIL abort_err: got %0d/%0d expected 1/1", err_m, fv_m); end
      @(negedge clk);
      checks++; if ({busy_m, done_m, a_m, b_m, c_m} !== 7'b00_01010) begin errors++;
         $display("FAIL abort_hold: got %b expected 0001010", {busy_m, done_m, a_m, b_m, c_m}); end
      pulse_start();
      checks++; if ({a_m, b_m, c_m, err_m, fv_m} !== 22'd0) begin errors++;
         $display("FAIL abort_clear: vec %0d err %0d fv %0d expected all 0", {a_m, b_m, c_m}, err_m, fv_m); end
      count_busy(cyc);
      checks++; if (cyc !== 32) begin errors++;
         $display("FAIL abort_rerun_len: got %0d expected 32", cyc); end
      checks++; if (err_m !== 16'd16) begin errors++;
         $display("FAIL abort_rerun_err: got %0d expected 16", err_m); end
   endtask

   task automatic test_back_to_back();
      int cyc;
      fault = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      count_busy(cyc);
      start = 1'b0;
      checks++; if (cyc !== 32) begin errors++;
         $display("FAIL held_len: got %0d expected 32", cyc); end
      checks++; if ({done_m, pass_m} !== 2'b11) begin errors++;
         $display("FAIL held_done: got %b expected 11", {done_m, pass_m}); end
      // start together with abort in DONE: start wins.
      abort = 1'b1;
      start = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      checks++; if ({busy_m, done_m, a_m, b_m, c_m} !== 7'b10_00000) begin errors++;
         $display("FAIL both_restart: got %b expected 1000000", {busy_m, done_m, a_m, b_m, c_m}); end
      count_busy(cyc);
      checks++; if (cyc !== 32) begin errors++;
         $display("FAIL both_len: got %0d expected 32", cyc); end
   endtask

   task automatic test_async_reset();
      fault = 1'b1;
      pulse_start();
      repeat (5) @(negedge clk);
      checks++; if ({busy_m, a_m, b_m, c_m} !== 6'b1_00101) begin errors++;
         $display("FAIL areset_pre: got %b expected 100101", {busy_m, a_m, b_m, c_m}); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({busy_m, done_m, pass_m, a_m, b_m, c_m} !== 8'd0) begin errors++;
         $display("FAIL areset_now: got %b expected 00000000", {busy_m, done_m, pass_m, a_m, b_m, c_m}); end
      checks++; if ({err_m, fa_m, fb_m, fc_m, fv_m} !== 22'd0) begin errors++;
         $display("FAIL areset_res: err %0d first %b expected 0", err_m, {fa_m, fb_m, fc_m, fv_m}); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if ({busy_m, done_m, a_m, b_m, c_m} !== 7'd0) begin errors++;
         $display("FAIL areset_idle: got %b expected 0000000", {busy_m, done_m, a_m, b_m, c_m}); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      start  = 1'b0;
      abort  = 1'b0;
      fault  = 1'b0;
      test_reset();
      test_sweep_pass();
      test_stuck_fault();
      test_abort();
      test_back_to_back();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
